// File: rtl/mole_pkg.sv
// Shared types and constants for the mole hit scorer.
// Holds the FSM state encoding, the score register address and a width helper.
package mole_pkg;

    typedef enum logic {
        LIT  = 1'b0,
        DARK = 1'b1
    } state_t;

    localparam logic [4:0] SCORE_REG = 5'd30;

    // Counter width able to hold values up to n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer for an active-low push button.
// level idles high; fall_pulse fires once per accepted 1->0 transition.
module btn_debounce
    import mole_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall_pulse
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Accept a new level only after it has been stable long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            level      <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    cnt        <= '0;
                    level      <= sync[1];
                    fall_pulse <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: LIT/DARK target FSM, saturating hit counter and
// a single-outstanding register-file write request. Option: MISS_PENALTY_EN.
module mole_hit_scorer
    import mole_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LIT_CYCLES      = 100000000,
    parameter int DARK_CYCLES     = 100000000,
    parameter int SCORE_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_in,
    input  logic               regfile_busy,
    output logic               mole_led,
    output logic [SCORE_W-1:0] score,
    output logic               wr_valid,
    output logic [4:0]         wr_reg,
    output logic [SCORE_W-1:0] wr_data
);

    localparam int PH_MAX = (LIT_CYCLES > DARK_CYCLES) ? LIT_CYCLES : DARK_CYCLES;
    localparam int PW = cnt_w(PH_MAX);
    localparam logic [PW-1:0] LIT_LAST  = PW'(LIT_CYCLES - 1);
    localparam logic [PW-1:0] DARK_LAST = PW'(DARK_CYCLES - 1);
    localparam logic [SCORE_W-1:0] ONES = {SCORE_W{1'b1}};

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      phase;
    logic               phase_clr;
    logic               press;
    logic               hit;
    logic               lit_timeout;
    logic [SCORE_W-1:0] score_nxt;
    logic               score_chg;
    logic               unused_level;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .raw       (btn_in),
        .level     (unused_level),
        .fall_pulse(press)
    );

    assign lit_timeout = (phase == LIT_LAST);

    // State register and phase counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LIT;
            phase <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_clr ? '0 : phase + 1'b1;
        end
    end

    // Next-state logic; a press on the final LIT cycle still scores.
    always_comb begin
        state_nxt = state;
        phase_clr = 1'b0;
        hit       = 1'b0;
        mole_led  = (state == LIT);
        unique case (state)
            LIT: begin
                if (press || lit_timeout) begin
                    hit       = press;
                    state_nxt = DARK;
                    phase_clr = 1'b1;
                end
            end
            DARK: begin
                if (phase == DARK_LAST) begin
                    state_nxt = LIT;
                    phase_clr = 1'b1;
                end
            end
            default: begin
                state_nxt = LIT;
                phase_clr = 1'b1;
            end
        endcase
    end

    // Saturating score update; misses optionally cost a point.
    always_comb begin
        score_nxt = score;
        if (hit) begin
            if (score != ONES) begin
                score_nxt = score + 1'b1;
            end
        end
`ifdef MISS_PENALTY_EN
        else if (state == LIT && lit_timeout) begin
            if (score != '0) begin
                score_nxt = score - 1'b1;
            end
        end
`endif
    end

    assign score_chg = (score_nxt != score);

    // Score register and write request held until a non-busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score    <= '0;
            wr_valid <= 1'b0;
        end else begin
            score    <= score_nxt;
            wr_valid <= score_chg | (wr_valid & regfile_busy);
        end
    end

    assign wr_reg  = SCORE_REG;
    assign wr_data = score;

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Directed bench for mole_hit_scorer with short debounce and phase windows.
// A negedge monitor tallies write requests, held cycles and accepts.
module tb_mole_hit_scorer;

    logic        clk;
    logic        reset;
    logic        btn_in;
    logic        regfile_busy;
    logic        mole_led;
    logic [31:0] score;
    logic        wr_valid;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    int checks;
    int failures;
    int cyc;

    int          n_wr;
    int          n_req;
    int          n_acc;
    logic [31:0] acc_data;
    logic        prev_v;

    mole_hit_scorer #(
        .DEBOUNCE_CYCLES(4),
        .LIT_CYCLES     (20),
        .DARK_CYCLES    (20),
        .SCORE_W        (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .regfile_busy(regfile_busy),
        .mole_led    (mole_led),
        .score       (score),
        .wr_valid    (wr_valid),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            n_wr     = 0;
            n_req    = 0;
            n_acc    = 0;
            acc_data = '0;
            prev_v   = 1'b0;
        end else begin
            if (wr_valid) n_wr++;
            if (wr_valid && !prev_v) n_req++;
            if (wr_valid && !regfile_busy) begin
                n_acc++;
                acc_data = wr_data;
            end
            prev_v = wr_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset;
        btn_in       = 1'b1;
        regfile_busy = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        btn_in       = 1'b1;
        regfile_busy = 1'b0;
        reset        = 1'b0;
        #3;

        // Reset state
        reset = 1'b1;
        #1;
        check("rst_led", 32'(mole_led), 1);
        check("rst_score", score, 0);
        check("rst_wrv", 32'(wr_valid), 0);
        check("rst_wreg", 32'(wr_reg), 30);

        // Single hit, press held 10 cycles, register file idle
        do_reset();
        wait_to(2);
        btn_in = 1'b0;
        wait_to(12);
        btn_in = 1'b1;
        wait_to(20);
        check("hit_score", score, 1);
        check("hit_led", 32'(mole_led), 0);
        check("hit_wr_cycles", 32'(n_wr), 1);
        check("hit_accepts", 32'(n_acc), 1);
        check("hit_wdata", acc_data, 1);

        // Short glitches are rejected
        do_reset();
        wait_to(2);
        for (int i = 0; i < 4; i++) begin
            btn_in = 1'b0;
            tick();
            tick();
            btn_in = 1'b1;
            tick();
            tick();
            tick();
        end
        wait_to(30);
        check("glitch_score", score, 0);
        check("glitch_wr", 32'(n_wr), 0);

        // Idle toggling every 20 cycles, no score change
        do_reset();
        wait_to(19);
        check("idle_led19", 32'(mole_led), 1);
        wait_to(20);
        check("idle_led20", 32'(mole_led), 0);
        wait_to(39);
        check("idle_led39", 32'(mole_led), 0);
        wait_to(40);
        check("idle_led40", 32'(mole_led), 1);
        wait_to(45);
        check("idle_score", score, 0);
        check("idle_wr", 32'(n_wr), 0);

        // Hit while busy, second hit before accept
        do_reset();
        regfile_busy = 1'b1;
        wait_to(2);
        btn_in = 1'b0;
        wait_to(12);
        btn_in = 1'b1;
        wait_to(20);
        check("busy_wrv_held", 32'(wr_valid), 1);
        check("busy_wdata1", wr_data, 1);
        wait_to(30);
        btn_in = 1'b0;
        wait_to(38);
        check("busy_wdata2", wr_data, 2);
        check("busy_wrv_still", 32'(wr_valid), 1);
        wait_to(40);
        btn_in       = 1'b1;
        regfile_busy = 1'b0;
        wait_to(42);
        check("busy_wrv_drop", 32'(wr_valid), 0);
        check("busy_reqs", 32'(n_req), 1);
        check("busy_accepts", 32'(n_acc), 1);
        check("busy_acc_data", acc_data, 2);
        check("busy_score", score, 2);

        // Press landing on the last LIT cycle counts as a hit
        do_reset();
        wait_to(13);
        btn_in = 1'b0;
        wait_to(21);
        check("edge_score", score, 1);
        check("edge_led", 32'(mole_led), 0);
        btn_in = 1'b1;
        wait_to(30);
        check("edge_accepts", 32'(n_acc), 1);

        // Press in DARK is ignored and DARK keeps its length
        do_reset();
        wait_to(21);
        btn_in = 1'b0;
        wait_to(29);
        btn_in = 1'b1;
        wait_to(39);
        check("dark_led39", 32'(mole_led), 0);
        wait_to(40);
        check("dark_led40", 32'(mole_led), 1);
        check("dark_score", score, 0);
        check("dark_wr", 32'(n_wr), 0);

        // Reset while a write is pending
        do_reset();
        regfile_busy = 1'b1;
        wait_to(2);
        btn_in = 1'b0;
        wait_to(11);
        check("rstw_pending", 32'(wr_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_wrv", 32'(wr_valid), 0);
        check("rstw_score", score, 0);
        check("rstw_led", 32'(mole_led), 1);
        btn_in       = 1'b1;
        regfile_busy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        wait_to(10);
        check("rstw_no_wr", 32'(n_wr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
